// File: rtl/axil_regbank.sv
// axil_regbank: AXI4-Lite register bank with RW control and RO status registers; define AXIL_REGBANK_STICKY_EN for sticky RO bits
module axil_regbank #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int NUM_REGS = 16,
  parameter int NUM_RO = 4,
  localparam int DW = C_S_AXI_DATA_WIDTH,
  localparam int NUM_RW = NUM_REGS - NUM_RO,
  localparam int ADDR_LSB = $clog2(DW / 8),
  localparam int IW = ((NUM_REGS > 1) ? $clog2(NUM_REGS) : 1) + 1,
  localparam int C_S_AXI_ADDR_WIDTH = ADDR_LSB + IW
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [2:0]                    S_AXI_AWPROT,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [DW-1:0]                 S_AXI_WDATA,
  input  logic [DW/8-1:0]               S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [2:0]                    S_AXI_ARPROT,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [DW-1:0]                 S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic [NUM_RW*DW-1:0]          ctrl_o,
  output logic [NUM_RW-1:0]             wr_pulse_o,
  input  logic [NUM_RO*DW-1:0]          status_i
);
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;
  wstate_t ws;
  rstate_t rs;
  logic aw_rdy, w_rdy, ar_rdy, bvalid, rvalid;
  logic [1:0] bresp, rresp;
  logic [DW-1:0] rdata, wdata_q, wd, rval;
  logic [DW/8-1:0] wstrb_q, wst;
  logic [IW-1:0] awidx_q, widx, ridx;
  logic [NUM_RW*DW-1:0] ctrl;
  logic [NUM_RW-1:0] pulse;
  logic [NUM_RO*DW-1:0] ro;
  logic aw_hs, w_hs, ar_hs, commit;
  logic unused;
  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};
  // Handshakes, effective write address/data from held or live channel, and read mux
  always_comb begin
    aw_hs = S_AXI_AWVALID & aw_rdy;
    w_hs = S_AXI_WVALID & w_rdy;
    ar_hs = S_AXI_ARVALID & ar_rdy;
    commit = (ws == W_IDLE) ? aw_hs & w_hs : (ws == W_ADDR) ? w_hs : (ws == W_DATA) ? aw_hs : 1'b0;
    widx = (ws == W_ADDR) ? awidx_q : S_AXI_AWADDR[ADDR_LSB +: IW];
    wd = (ws == W_DATA) ? wdata_q : S_AXI_WDATA;
    wst = (ws == W_DATA) ? wstrb_q : S_AXI_WSTRB;
    ridx = S_AXI_ARADDR[ADDR_LSB +: IW];
    rval = '0;
    for (int k = 0; k < NUM_RW; k++) if (ridx == IW'(k)) rval = ctrl[k*DW +: DW];
    for (int j = 0; j < NUM_RO; j++) if (ridx == IW'(NUM_RW + j)) rval = ro[j*DW +: DW];
  end
  // Write FSM: capture AW/W in any order, commit on the edge both are held, then respond
  always_ff @(posedge ACLK)
    if (ARESET) begin
      ws <= W_IDLE;
      aw_rdy <= 1'b0;
      w_rdy <= 1'b0;
      bvalid <= 1'b0;
      bresp <= 2'b00;
      awidx_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      ctrl <= '0;
      pulse <= '0;
    end else begin
      pulse <= '0;
      if (commit) begin
        ws <= W_RESP;
        aw_rdy <= 1'b0;
        w_rdy <= 1'b0;
        bvalid <= 1'b1;
        bresp <= (widx < IW'(NUM_REGS)) ? 2'b00 : 2'b10;
        for (int k = 0; k < NUM_RW; k++)
          if (widx == IW'(k)) begin
            pulse[k] <= 1'b1;
            for (int b = 0; b < DW/8; b++) if (wst[b]) ctrl[k*DW + 8*b +: 8] <= wd[8*b +: 8];
          end
      end else
        case (ws)
          W_IDLE: begin
            aw_rdy <= ~aw_hs;
            w_rdy <= ~w_hs;
            ws <= aw_hs ? W_ADDR : w_hs ? W_DATA : W_IDLE;
            if (aw_hs) awidx_q <= widx;
            if (w_hs) begin
              wdata_q <= S_AXI_WDATA;
              wstrb_q <= S_AXI_WSTRB;
            end
          end
          W_RESP:
            if (S_AXI_BREADY) begin
              ws <= W_IDLE;
              bvalid <= 1'b0;
              aw_rdy <= 1'b1;
              w_rdy <= 1'b1;
            end
          default: ws <= ws;
        endcase
    end
  // Read FSM: sample the register on the AR handshake and hold it until RREADY
  always_ff @(posedge ACLK)
    if (ARESET) begin
      rs <= R_IDLE;
      ar_rdy <= 1'b0;
      rvalid <= 1'b0;
      rresp <= 2'b00;
      rdata <= '0;
    end else if (rs == R_IDLE) begin
      ar_rdy <= ~ar_hs;
      if (ar_hs) begin
        rs <= R_DATA;
        rvalid <= 1'b1;
        rdata <= rval;
        rresp <= (ridx < IW'(NUM_REGS)) ? 2'b00 : 2'b10;
      end
    end else if (S_AXI_RREADY) begin
      rs <= R_IDLE;
      rvalid <= 1'b0;
      ar_rdy <= 1'b1;
    end
`ifdef AXIL_REGBANK_STICKY_EN
  logic [NUM_RO*DW-1:0] st, clr;
  // Write-one-to-clear mask for RO registers, gated by byte strobes
  always_comb begin
    clr = '0;
    for (int j = 0; j < NUM_RO; j++)
      for (int b = 0; b < DW/8; b++)
        if (commit && widx == IW'(NUM_RW + j) && wst[b]) clr[j*DW + 8*b +: 8] = wd[8*b +: 8];
  end
  // Sticky status: new status bits set after the clear so a same-cycle set wins
  always_ff @(posedge ACLK)
    st <= ARESET ? '0 : (st & ~clr) | status_i;
  assign ro = st;
`else
  assign ro = status_i;
`endif
  assign S_AXI_AWREADY = aw_rdy;
  assign S_AXI_WREADY = w_rdy;
  assign S_AXI_BVALID = bvalid;
  assign S_AXI_BRESP = bresp;
  assign S_AXI_ARREADY = ar_rdy;
  assign S_AXI_RVALID = rvalid;
  assign S_AXI_RRESP = rresp;
  assign S_AXI_RDATA = rdata;
  assign ctrl_o = ctrl;
  assign wr_pulse_o = pulse;
endmodule

// File: doc/axil_regbank.md
AXIL_REGBANK -- requirements
Module: axil_regbank

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI data width; legal values 32 or 64.
REQ-002 SHALL have parameter NUM_REGS, default 16, total register count; legal range 2..256.
REQ-003 SHALL have parameter NUM_RO, default 4, count of read-only status registers occupying the top indices; legal range 0..NUM_REGS-1.
REQ-004 SHALL have derived localparams: NUM_RW = NUM_REGS-NUM_RO; ADDR_LSB = log2(C_S_AXI_DATA_WIDTH/8); C_S_AXI_ADDR_WIDTH = ADDR_LSB + max(1, ceil(log2(NUM_REGS))) + 1.
REQ-005 SHALL have port ACLK, input, 1, single clock for all logic; one clock domain.
REQ-006 SHALL have port ARESET, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have ports S_AXI_AWADDR/AWPROT/AWVALID/AWREADY, S_AXI_WDATA/WSTRB/WVALID/WREADY and S_AXI_BRESP/BVALID/BREADY with standard AXI4-Lite directions and widths.
REQ-008 SHALL have ports S_AXI_ARADDR/ARPROT/ARVALID/ARREADY and S_AXI_RDATA/RRESP/RVALID/RREADY with standard AXI4-Lite directions and widths.
REQ-009 SHALL have port ctrl_o, output, NUM_RW*C_S_AXI_DATA_WIDTH, flattened RW register contents; register k occupies bits [k*DW +: DW].
REQ-010 SHALL have port wr_pulse_o, output, NUM_RW, one-cycle pulse for each RW register on write commit.
REQ-011 SHALL have port status_i, input, NUM_RO*C_S_AXI_DATA_WIDTH, status values feeding the RO registers.

Function
REQ-012 SHALL decode register index = ADDR[ADDR_LSB +: idx bits]; index >= NUM_REGS is out of range.
REQ-013 SHALL run the write FSM through states W_IDLE, W_ADDR (AW held), W_DATA (W held) and W_RESP; AW and W SHALL be accepted in either order or in the same cycle.
REQ-014 SHALL assert AWREADY only in W_IDLE/W_DATA and WREADY only in W_IDLE/W_ADDR; at most one write SHALL be outstanding.
REQ-015 SHALL commit a write in the cycle after both AW and W are captured; BVALID SHALL rise in that same commit cycle and hold until BREADY.
REQ-016 SHALL apply WSTRB per byte; a byte with strobe 0 keeps its old value.
REQ-017 SHALL make RO-index writes change nothing and respond OKAY.
REQ-018 SHALL make out-of-range writes change nothing and respond SLVERR (2'b10).
REQ-019 SHALL pulse wr_pulse_o[k] for one cycle on commit to RW register k, including when WSTRB is 0.
REQ-020 SHALL run the read FSM through states R_IDLE and R_DATA; ARREADY SHALL be high only in R_IDLE.
REQ-021 SHALL register RDATA one cycle after the AR handshake and hold RVALID and RDATA stable until RREADY.
REQ-022 SHALL make out-of-range reads return RDATA 0 with RRESP SLVERR.
REQ-023 SHALL run the read and write channels concurrently; a read handshaken in the same cycle as a write commit to the same register SHALL return the pre-write value.
REQ-024 SHALL ignore AWPROT and ARPROT.

Reset
REQ-025 SHALL, while ARESET is high at a clock edge, clear all RW registers, ctrl_o and wr_pulse_o to 0; set both FSMs to idle; and drive AWREADY, WREADY, ARREADY, BVALID, RVALID = 0, BRESP = RRESP = 0 and RDATA = 0.
REQ-026 SHALL abandon any transaction in progress when reset is asserted, with no commit, pulse or response afterwards; READY signals SHALL rise on the first cycle after reset deasserts.

Configuration
REQ-027 SHALL make RO registers sticky when AXIL_REGBANK_STICKY_EN is defined: each bit ORs in status_i every cycle, a write of 1 clears that bit under WSTRB, set wins over clear in the same cycle, and reset value is 0.
REQ-028 SHALL, when AXIL_REGBANK_STICKY_EN is not defined, make RO reads return live status_i sampled at the AR handshake, with RO writes ignored per REQ-017.

Verification
REQ-029 SHALL cover: reset, then write 0x1,0x2,0x3,0x4 to addresses 0x0,0x4,0x8,0xC, then read all four -> data 0x1..0x4 with OKAY; wr_pulse_o[0..3] each pulse once.
REQ-030 SHALL cover: W presented 3 cycles before AW for address 0x4, data 0xDEADBEEF -> single commit; BVALID held until BREADY is asserted 5 cycles later; ctrl_o reg1 = 0xDEADBEEF.
REQ-031 SHALL cover: reg0 = 0xFFFFFFFF, then write 0x00000000 with WSTRB 4'b0101 -> readback 0xFF00FF00.
REQ-032 SHALL cover: write and read at index NUM_REGS (address 0x40 at defaults) -> BRESP and RRESP SLVERR, RDATA 0, no wr_pulse_o.
REQ-033 SHALL cover: with AXIL_REGBANK_STICKY_EN, status_i reg12 = 0x1 pulsed for 1 cycle -> reads 0x1; write 0x1 -> reads 0x0; set and clear in the same cycle -> reads 0x1.
REQ-034 SHALL cover: ARESET asserted between AW and W handshakes -> no commit, BVALID stays 0, and reg reads 0 after reset.
